// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel framebuffer writer.
// Holds the capture FSM state encoding and the RGB888 -> RGB565 packing.
package pixel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    // Keep the top bits of each channel: 5 for R, 6 for G, 5 for B.
    function automatic logic [15:0] rgb888_to_565(input logic [23:0] pix);
        return {pix[23:19], pix[15:10], pix[7:3]};
    endfunction

endpackage

// File: rtl/pixel_fb_writer.sv
// Captures one AXI-stream frame per frame_start and writes it as RGB565 in raster order.
// Latency: accepted beat in cycle N -> fb_we in cycle N+1; tready is a pure function of state.
module pixel_fb_writer
    import pixel_pkg::*;
#(
    parameter int H_RES  = 320,
    parameter int V_RES  = 180,
    parameter int ADDR_W = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [23:0]       pixel_axis_tdata,
    input  logic              pixel_axis_tvalid,
    output logic              pixel_axis_tready,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [15:0]       fb_wdata,
    output logic              fb_we,
    output logic              busy,
    output logic              frame_done
);

    localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    state_e            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [15:0]       fb_wdata_q, fb_wdata_d;
    logic              fb_we_q, fb_we_d;
    logic              frame_done_q, frame_done_d;
    logic              beat_acc;

    assign beat_acc = pixel_axis_tvalid && (state_q == ST_ACTIVE);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        addr_d       = addr_q;
        fb_addr_d    = fb_addr_q;
        fb_wdata_d   = fb_wdata_q;
        fb_we_d      = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                end
            end
            ST_ACTIVE: begin
                if (beat_acc) begin
                    fb_we_d    = 1'b1;
                    fb_addr_d  = addr_q;
                    fb_wdata_d = rgb888_to_565(pixel_axis_tdata);
                    addr_d     = addr_q + 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        // Last pixel of the frame: its write lands in the FLUSH cycle.
                        if (y_q == Y_LAST) begin
                            state_d      = ST_FLUSH;
                            frame_done_d = 1'b1;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            fb_addr_q    <= '0;
            fb_wdata_q   <= '0;
            fb_we_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
            fb_we_q      <= fb_we_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pixel_axis_tready = (state_q == ST_ACTIVE);
    assign busy              = (state_q != ST_IDLE);
    assign fb_addr           = fb_addr_q;
    assign fb_wdata          = fb_wdata_q;
    assign fb_we             = fb_we_q;
    assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Bench for pixel_fb_writer: a 4x2 instance checked every cycle against a pixel-count model,
// plus a default-size instance run over one full frame.
module tb_pixel_fb_writer;

    localparam int TOTAL = 8;
    localparam int BIG_TOTAL = 320 * 180;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic [23:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        frame_start = 1'b0;
    logic        tready, fb_we, busy, frame_done;
    logic [3:0]  fb_addr;
    logic [15:0] fb_wdata;

    pixel_fb_writer #(.H_RES(4), .V_RES(2), .ADDR_W(4)) dut (
        .aclk(clk), .areset(rst),
        .pixel_axis_tdata(tdata), .pixel_axis_tvalid(tvalid), .pixel_axis_tready(tready),
        .frame_start(frame_start),
        .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_we(fb_we),
        .busy(busy), .frame_done(frame_done)
    );

    logic        rst2 = 1'b0;
    logic [23:0] td2 = '0;
    logic        tv2 = 1'b0;
    logic        fs2 = 1'b0;
    logic        tready2, we2, busy2, done2;
    logic [15:0] addr2;
    logic [15:0] wdata2;

    pixel_fb_writer big (
        .aclk(clk), .areset(rst2),
        .pixel_axis_tdata(td2), .pixel_axis_tvalid(tv2), .pixel_axis_tready(tready2),
        .frame_start(fs2),
        .fb_addr(addr2), .fb_wdata(wdata2), .fb_we(we2),
        .busy(busy2), .frame_done(done2)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to565(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
    endfunction

    // Model: a frame is "open" from frame_start until TOTAL pixels are taken,
    // followed by one closing cycle where new requests are dropped.
    int          m_phase = 0;   // 0 waiting, 1 taking pixels, 2 closing
    int          m_n = 0;
    logic        exp_we = 0, exp_done = 0;
    logic [15:0] exp_addr = 0, exp_wdata = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = 0; m_n = 0;
                exp_we = 0; exp_done = 0; exp_addr = 0; exp_wdata = 0;
            end else begin
                exp_we = 0;
                exp_done = 0;
                if (m_phase == 0) begin
                    if (frame_start) begin m_phase = 1; m_n = 0; end
                end else if (m_phase == 1) begin
                    if (tvalid) begin
                        exp_we = 1;
                        exp_addr = 16'(m_n);
                        exp_wdata = to565(tdata);
                        m_n++;
                        if (m_n == TOTAL) begin exp_done = 1; m_phase = 2; end
                    end
                end else begin
                    m_phase = 0;
                end
            end
        end
    end

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        done;
        int          cyc;
    } wr_t;
    wr_t log_q[$];
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            check("tready", 32'(tready), 32'(m_phase == 1));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("fb_we", 32'(fb_we), 32'(exp_we));
            check("frame_done", 32'(frame_done), 32'(exp_done));
            check("fb_addr", 32'(fb_addr), 32'(exp_addr));
            check("fb_wdata", 32'(fb_wdata), 32'(exp_wdata));
            if (fb_we) log_q.push_back('{addr: 16'(fb_addr), data: fb_wdata, done: frame_done, cyc: cyc});
        end
    end

    task automatic start_frame();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int k = 0; k < 30; k++) begin
            tdata = 24'($urandom);
            @(negedge clk);
            if (frame_done) begin seen = 1; break; end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    bit tv_pat [12] = '{1, 0, 1, 0, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        int cnt;
        int ndone;
        bit seen;

        #1 rst = 1'b1; rst2 = 1'b1;
        #2;
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tready", 32'(tready), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_wdata", 32'(fb_wdata), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;

        // Frame A: start and first valid together, then 8 back-to-back beats
        @(negedge clk); frame_start = 1'b1; tvalid = 1'b1; tdata = '0;
        @(negedge clk); frame_start = 1'b0;
        check("A_no_early_write", 32'(log_q.size()), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tdata = 24'(i) * 24'h010101;
            @(negedge clk);
        end
        tvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("A_count", 32'(log_q.size()), 32'd8);
        if (log_q.size() == 8) begin
            ndone = 0;
            for (int k = 0; k < 8; k++) begin
                check("A_addr", 32'(log_q[k].addr), 32'(k));
                ndone += int'(log_q[k].done);
            end
            check("A_done_at_7", 32'(log_q[7].done), 32'd1);
            check("A_one_done", 32'(ndone), 32'd1);
            check("A_consecutive", 32'(log_q[7].cyc - log_q[0].cyc), 32'd7);
            check("A_data7", 32'(log_q[7].data), 32'h0020);
        end
        check("A_idle_after", 32'(busy), 32'd0);

        // Frame B: gappy valid, frame_start pulsed mid-frame, known colour first
        log_q.delete();
        start_frame();
        for (int s = 0; s < 12; s++) begin
            tvalid = tv_pat[s];
            tdata = tv_pat[s] ? ((s == 0) ? 24'hFF8040 : 24'(s) * 24'h102030) : 24'hABCDEF;
            frame_start = (s == 5);
            @(negedge clk);
        end
        frame_start = 1'b0; tvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("B_count", 32'(log_q.size()), 32'd8);
        if (log_q.size() == 8) begin
            ndone = 0;
            for (int k = 0; k < 8; k++) begin
                check("B_addr", 32'(log_q[k].addr), 32'(k));
                ndone += int'(log_q[k].done);
            end
            check("B_rgb565_FF8040", 32'(log_q[0].data), 32'hFC08);
            check("B_one_done", 32'(ndone), 32'd1);
            check("B_done_at_7", 32'(log_q[7].done), 32'd1);
        end

        // Frame C: reset after 5 accepted beats
        log_q.delete();
        start_frame();
        tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tdata = 24'($urandom);
            @(negedge clk);
        end
        tvalid = 1'b0;
        #2;
        check("C_we_before_rst", 32'(fb_we), 32'd1);
        rst = 1'b1;
        #1;
        check("C_we_in_rst", 32'(fb_we), 32'd0);
        check("C_busy_in_rst", 32'(busy), 32'd0);
        check("C_tready_in_rst", 32'(tready), 32'd0);
        check("C_addr_in_rst", 32'(fb_addr), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        check("C_waits_start", 32'(busy), 32'd0);
        check("C_writes", 32'(log_q.size()), 32'd5);

        // Frame D: restart at 0; frame_start in FLUSH dropped, in the next cycle honoured
        log_q.delete();
        start_frame();
        tvalid = 1'b1;
        wait_done("D_done_seen");
        tvalid = 1'b0; frame_start = 1'b1;
        @(negedge clk);
        check("D_flush_start_ignored", 32'(busy), 32'd0);
        @(negedge clk);
        frame_start = 1'b0;
        check("D_idle_start_busy", 32'(busy), 32'd1);
        check("D_idle_start_tready", 32'(tready), 32'd1);
        if (log_q.size() > 0) check("D_first_addr", 32'(log_q[0].addr), 32'd0);

        // Frame E: the frame opened above runs to completion
        tvalid = 1'b1;
        wait_done("E_done_seen");
        tvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("DE_count", 32'(log_q.size()), 32'd16);
        if (log_q.size() == 16) begin
            check("E_first_addr", 32'(log_q[8].addr), 32'd0);
            check("E_last_addr", 32'(log_q[15].addr), 32'd7);
        end

        // Default-size frame on the second instance
        @(negedge clk); fs2 = 1'b1;
        @(negedge clk); fs2 = 1'b0; tv2 = 1'b1;
        cnt = 0;
        seen = 0;
        for (int k = 0; k < BIG_TOTAL + 20; k++) begin
            td2 = 24'($urandom);
            @(negedge clk);
            if (we2) begin
                check("BIG_addr", 32'(addr2), 32'(cnt));
                cnt++;
            end
            if (done2) begin seen = 1; break; end
        end
        check("BIG_done_seen", 32'(seen), 32'd1);
        check("BIG_last_addr", 32'(addr2), 32'd57599);
        check("BIG_count", 32'(cnt), 32'(BIG_TOTAL));
        check("BIG_tready_after_last", 32'(tready2), 32'd0);
        tv2 = 1'b0;
        @(negedge clk);
        check("BIG_idle", 32'(busy2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
